// File: rtl/score_tally_if.sv
// score_tally_if: keycode/lane inputs and score readout outputs of the scoring stage
interface score_tally_if #(parameter int N_LANES = 64);
  logic [7:0] keycode;
  logic [N_LANES-1:0] score_vec;
  logic [13:0] total_score;
  logic [7:0] hit_count;
  logic [6:0] pending_cnt;
  logic [15:0] bcd_digits;
  logic bcd_busy;
  logic playing;
  modport master(output keycode, score_vec, input total_score, hit_count, pending_cnt, bcd_digits, bcd_busy, playing);
  modport slave(input keycode, score_vec, output total_score, hit_count, pending_cnt, bcd_digits, bcd_busy, playing);
endinterface

// File: rtl/score_tally.sv
// score_tally: counts each dropper hit once into a saturating total/hit count; BCD readout built only with SCORE_TALLY_BCD_EN
module score_tally #(
  parameter int N_LANES = 64,
  parameter int POINTS = 10,
  parameter int SCORE_MAX = 9999
) (
  input logic frame_clk,
  input logic Reset,
  score_tally_if.slave bus
);
  typedef enum logic {IDLE, PLAY} mode_t;
  mode_t mode_q, mode_d;
  logic [N_LANES-1:0] prev_q, pending_q, pending_d, new_hit, svc;
  logic [13:0] total_q, total_d;
  logic [7:0] hits_q, hits_d;
  logic [6:0] pcnt_q, pcnt_d;
  logic [14:0] total_sum;
  logic play, restart, serve;
  assign play = mode_q == PLAY;
  assign restart = play && bus.keycode == 8'h01;
  assign serve = play && |pending_q;
  assign new_hit = play ? bus.score_vec & ~prev_q : '0;
  assign svc = pending_q & -pending_q;
  assign total_sum = {1'b0, total_q} + 15'(POINTS);
  always_comb begin
    mode_d = restart ? IDLE : (!play && bus.keycode == 8'h2C) ? PLAY : mode_q;
    pending_d = restart ? '0 : (pending_q & ~svc) | new_hit;
    total_d = restart ? '0 : !serve ? total_q : total_sum > 15'(SCORE_MAX) ? 14'(SCORE_MAX) : total_sum[13:0];
    hits_d = restart ? '0 : (serve && hits_q != 8'hFF) ? hits_q + 8'd1 : hits_q;
    pcnt_d = '0;
    for (int i = 0; i < N_LANES; i++) pcnt_d += 7'(pending_d[i]);
  end
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      mode_q <= IDLE;
      prev_q <= '0;
      pending_q <= '0;
      total_q <= '0;
      hits_q <= '0;
      pcnt_q <= '0;
    end else begin
      mode_q <= mode_d;
      prev_q <= bus.score_vec;
      pending_q <= pending_d;
      total_q <= total_d;
      hits_q <= hits_d;
      pcnt_q <= pcnt_d;
    end
  end
  assign bus.total_score = total_q;
  assign bus.hit_count = hits_q;
  assign bus.pending_cnt = pcnt_q;
  assign bus.playing = play;
`ifdef SCORE_TALLY_BCD_EN
  typedef enum logic [1:0] {B_IDLE, B_SHIFT, B_DONE} bstate_t;
  bstate_t bst_q, bst_d;
  logic dirty_q, dirty_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] scr_q, scr_d, adj, digits_q, digits_d;
  logic [3:0] cnt_q, cnt_d;
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < 4; i++) if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
    bst_d = bst_q;
    dirty_d = dirty_q | (total_d != total_q);
    bin_d = bin_q;
    scr_d = scr_q;
    cnt_d = cnt_q;
    digits_d = digits_q;
    // restart zeroes the readout directly and drops any conversion in flight
    if (restart) begin
      bst_d = B_IDLE;
      dirty_d = 1'b0;
      digits_d = '0;
    end else begin
      case (bst_q)
        B_IDLE: if (dirty_q) begin
          bst_d = B_SHIFT;
          dirty_d = total_d != total_q;
          bin_d = total_q;
          scr_d = '0;
          cnt_d = '0;
        end
        B_SHIFT: begin
          {scr_d, bin_d} = {adj, bin_q} << 1;
          cnt_d = cnt_q + 4'd1;
          bst_d = cnt_q == 4'd13 ? B_DONE : B_SHIFT;
        end
        B_DONE: begin
          digits_d = scr_q;
          bst_d = B_IDLE;
        end
        default: bst_d = B_IDLE;
      endcase
    end
  end
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      bst_q <= B_IDLE;
      dirty_q <= 1'b0;
      bin_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      digits_q <= '0;
    end else begin
      bst_q <= bst_d;
      dirty_q <= dirty_d;
      bin_q <= bin_d;
      scr_q <= scr_d;
      cnt_q <= cnt_d;
      digits_q <= digits_d;
    end
  end
  assign bus.bcd_digits = digits_q;
  assign bus.bcd_busy = bst_q != B_IDLE;
`else
  assign bus.bcd_digits = '0;
  assign bus.bcd_busy = 1'b0;
`endif
endmodule

// File: tb/tb_score_tally.sv
// tb_score_tally: randomized and directed checks of score_tally against a cycle-level behavioural model
module tb_score_tally;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  score_tally_if #(.N_LANES(64)) bus();
  score_tally #(.N_LANES(64), .POINTS(10), .SCORE_MAX(9999)) dut (.frame_clk(clk), .Reset(rst), .bus(bus));
  int n_checks = 0, n_errs = 0;
  bit m_play;
  bit [63:0] m_prev, m_pend;
  int m_total, m_hits;
  logic [29:0] core;
  assign core = {bus.total_score, bus.hit_count, bus.pending_cnt, bus.playing};
  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  function automatic logic [15:0] exp_digits();
`ifdef SCORE_TALLY_BCD_EN
    return to_bcd(m_total);
`else
    return 16'h0;
`endif
  endfunction
  function automatic logic [29:0] exp_core();
    return {14'(m_total), 8'(m_hits), 7'($countones(m_pend)), m_play};
  endfunction
  task automatic model_edge();
    int low;
    logic [63:0] sv;
    logic [7:0] kc;
    sv = bus.score_vec;
    kc = bus.keycode;
    if (rst) begin
      m_play = 0; m_prev = '0; m_pend = '0; m_total = 0; m_hits = 0;
      return;
    end
    if (m_play && kc == 8'h01) begin
      m_play = 0; m_pend = '0; m_total = 0; m_hits = 0;
    end else if (m_play) begin
      low = -1;
      for (int i = 63; i >= 0; i--) if (m_pend[i]) low = i;
      if (low >= 0) begin
        m_pend[low] = 1'b0;
        m_total = (m_total + 10 > 9999) ? 9999 : m_total + 10;
        m_hits = (m_hits < 255) ? m_hits + 1 : 255;
      end
      m_pend |= sv & ~m_prev;
    end else if (kc == 8'h2C) m_play = 1;
    m_prev = sv;
  endtask
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.keycode = 8'h2C;
    bus.score_vec = {$urandom, $urandom};
    tick();
    tick();
    rst = 1'b0;
    bus.keycode = 8'h00;
    bus.score_vec = '0;
    n_checks++; if (core !== 30'h0) begin n_errs++; $display("FAIL reset_core: got %h want 0", core); end
    n_checks++; if ({bus.bcd_digits, bus.bcd_busy} !== 17'h0) begin n_errs++; $display("FAIL reset_bcd: got %h want 0", {bus.bcd_digits, bus.bcd_busy}); end
  endtask
  task automatic test_single_hit();
    logic exp_busy;
`ifdef SCORE_TALLY_BCD_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    bus.keycode = 8'h2C;
    tick();
    bus.keycode = 8'h00;
    n_checks++; if (bus.playing !== 1'b1) begin n_errs++; $display("FAIL start_playing: got %b want 1", bus.playing); end
    bus.score_vec[5] = 1'b1;
    tick();
    n_checks++; if (core !== exp_core()) begin n_errs++; $display("FAIL single_edge: got %h want %h", core, exp_core()); end
    tick();
    n_checks++; if ({bus.total_score, bus.hit_count} !== {14'd10, 8'd1}) begin n_errs++; $display("FAIL single_total: got %0d/%0d want 10/1", bus.total_score, bus.hit_count); end
    for (int i = 0; i < 15; i++) tick();
    n_checks++; if ({bus.bcd_digits, bus.bcd_busy} !== {16'h0, exp_busy}) begin n_errs++; $display("FAIL bcd_early: got %h/%b want 0/%b", bus.bcd_digits, bus.bcd_busy, exp_busy); end
    tick();
    n_checks++; if ({bus.bcd_digits, bus.bcd_busy} !== {exp_digits(), 1'b0}) begin n_errs++; $display("FAIL bcd_16: got %h/%b want %h/0", bus.bcd_digits, bus.bcd_busy, exp_digits()); end
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (core !== exp_core() || bus.total_score !== 14'd10) begin n_errs++; $display("FAIL single_hold: got %h want %h", core, exp_core()); end
    bus.score_vec = '0;
    tick();
  endtask
  task automatic test_multi_lane();
    int base;
    base = m_total;
    bus.score_vec[3] = 1'b1;
    bus.score_vec[17] = 1'b1;
    bus.score_vec[40] = 1'b1;
    tick();
    n_checks++; if (bus.pending_cnt !== 7'd3 || core !== exp_core()) begin n_errs++; $display("FAIL multi_pending: got %h want %h", core, exp_core()); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++; if (bus.total_score !== 14'(base + 10 * i) || core !== exp_core()) begin n_errs++; $display("FAIL multi_step%0d: got %h want %h", i, core, exp_core()); end
    end
    bus.score_vec = '0;
    tick();
  endtask
  task automatic test_idle_high();
    bus.keycode = 8'h01;
    tick();
    bus.keycode = 8'h00;
    bus.score_vec[2] = 1'b1;
    tick();
    tick();
    bus.keycode = 8'h2C;
    tick();
    bus.keycode = 8'h00;
    for (int i = 0; i < 4; i++) tick();
    n_checks++; if (bus.hit_count !== 8'd0 || bus.playing !== 1'b1 || core !== exp_core()) begin n_errs++; $display("FAIL idle_high: got %h want %h", core, exp_core()); end
    bus.score_vec[2] = 1'b0;
    tick();
    bus.score_vec[2] = 1'b1;
    tick();
    tick();
    tick();
    n_checks++; if (bus.hit_count !== 8'd1 || core !== exp_core()) begin n_errs++; $display("FAIL idle_rehit: got %h want %h", core, exp_core()); end
  endtask
  task automatic test_restart_pending();
    bus.score_vec[9] = 1'b1;
    bus.score_vec[30] = 1'b1;
    tick();
    n_checks++; if (bus.pending_cnt !== 7'd2) begin n_errs++; $display("FAIL restart_pre: got %0d want 2", bus.pending_cnt); end
    bus.keycode = 8'h01;
    tick();
    bus.keycode = 8'h00;
    n_checks++; if (core !== 30'h0 || core !== exp_core()) begin n_errs++; $display("FAIL restart_core: got %h want 0", core); end
    n_checks++; if (bus.bcd_digits !== 16'h0) begin n_errs++; $display("FAIL restart_bcd: got %h want 0", bus.bcd_digits); end
    bus.score_vec = '0;
    tick();
  endtask
  task automatic test_back_to_back();
    bus.keycode = 8'h2C;
    tick();
    bus.keycode = 8'h00;
    bus.score_vec[0] = 1'b1;
    tick();
    bus.score_vec[0] = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) tick();
    bus.score_vec[1] = 1'b1;
    tick();
    bus.score_vec[1] = 1'b0;
    tick();
    n_checks++; if (bus.total_score !== 14'd20 || core !== exp_core()) begin n_errs++; $display("FAIL b2b_total: got %h want %h", core, exp_core()); end
    for (int i = 0; i < 32; i++) tick();
    n_checks++; if ({bus.bcd_digits, bus.bcd_busy} !== {exp_digits(), 1'b0}) begin n_errs++; $display("FAIL b2b_bcd: got %h/%b want %h/0", bus.bcd_digits, bus.bcd_busy, exp_digits()); end
  endtask
  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      bus.score_vec ^= {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      r = $urandom_range(0, 99);
      bus.keycode = (r == 0) ? 8'h01 : (r < 4) ? 8'h2C : 8'h00;
      tick();
      n_checks++; if (core !== exp_core()) begin n_errs++; $display("FAIL rand_c%0d: got %h want %h", c, core, exp_core()); end
    end
    bus.keycode = 8'h00;
    for (int i = 0; i < 150; i++) tick();
    n_checks++; if ({bus.bcd_digits, bus.bcd_busy} !== {exp_digits(), 1'b0} || core !== exp_core()) begin n_errs++; $display("FAIL rand_settle: got %h/%h want %h/%h", bus.bcd_digits, core, exp_digits(), exp_core()); end
    bus.score_vec = '0;
    bus.keycode = m_play ? 8'h01 : 8'h00;
    tick();
    bus.keycode = 8'h00;
  endtask
  task automatic test_saturate();
    int c;
    logic [15:0] want;
`ifdef SCORE_TALLY_BCD_EN
    want = 16'h9999;
`else
    want = 16'h0;
`endif
    bus.keycode = 8'h2C;
    tick();
    bus.keycode = 8'h00;
    for (c = 0; c < 3000 && m_total < 9990; c++) begin
      bus.score_vec = (c % 2 == 0) ? '1 : '0;
      tick();
      n_checks++; if (core !== exp_core()) begin n_errs++; $display("FAIL sat_c%0d: got %h want %h", c, core, exp_core()); end
    end
    n_checks++; if (bus.total_score !== 14'd9990) begin n_errs++; $display("FAIL sat_9990: got %0d want 9990", bus.total_score); end
    bus.score_vec = (c % 2 == 0) ? '1 : '0;
    tick();
    n_checks++; if (bus.total_score !== 14'd9999) begin n_errs++; $display("FAIL sat_9999: got %0d want 9999", bus.total_score); end
    bus.score_vec = ~bus.score_vec;
    tick();
    n_checks++; if (bus.total_score !== 14'd9999 || bus.hit_count !== 8'd255 || core !== exp_core()) begin n_errs++; $display("FAIL sat_hold: got %h want %h", core, exp_core()); end
    bus.score_vec = '0;
    for (int i = 0; i < 120; i++) tick();
    n_checks++; if (bus.pending_cnt !== 7'd0 || core !== exp_core()) begin n_errs++; $display("FAIL sat_drain: got %h want %h", core, exp_core()); end
    n_checks++; if (bus.bcd_digits !== want) begin n_errs++; $display("FAIL sat_bcd: got %h want %h", bus.bcd_digits, want); end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.keycode = 8'h00;
    bus.score_vec = '0;
    test_reset();
    test_single_hit();
    test_multi_lane();
    test_idle_high();
    test_restart_pending();
    test_back_to_back();
    test_random();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
